// File: rtl/ssio_ddr_in_delay_ctrl_if.sv
// Bus bundle for the DDR input delay calibration controller: training data in,
// delay-element control and scan result out.
interface ssio_ddr_in_delay_ctrl_if #(
   parameter int WIDTH     = 4,
   parameter int TAP_WIDTH = 5
);
   logic                 start;
   logic [WIDTH-1:0]     pattern_q1;
   logic [WIDTH-1:0]     pattern_q2;
   logic [WIDTH-1:0]     input_q1;
   logic [WIDTH-1:0]     input_q2;
   logic [TAP_WIDTH-1:0] delay_tap;
   logic                 delay_load;
   logic                 busy;
   logic                 done;
   logic                 locked;
   logic                 error;
   logic [TAP_WIDTH-1:0] window_start;
   logic [TAP_WIDTH-1:0] window_end;

   modport master (
      output start, pattern_q1, pattern_q2, input_q1, input_q2,
      input  delay_tap, delay_load, busy, done, locked, error, window_start, window_end
   );

   modport slave (
      input  start, pattern_q1, pattern_q2, input_q1, input_q2,
      output delay_tap, delay_load, busy, done, locked, error, window_start, window_end
   );
endinterface

// File: rtl/ssio_ddr_in_delay_ctrl.sv
// Scans every delay tap, finds the longest run of taps whose captured DDR data
// matches the training pattern, and parks the delay in the middle of that run.
module ssio_ddr_in_delay_ctrl #(
   parameter int WIDTH         = 4,
   parameter int TAP_WIDTH     = 5,
   parameter int SETTLE_CYCLES = 16,
   parameter int SAMPLE_CYCLES = 64,
   parameter int MIN_WINDOW    = 3
) (
   input logic                    clk,
   input logic                    rst,
   ssio_ddr_in_delay_ctrl_if.slave bus
);
   localparam int LEN_W   = TAP_WIDTH + 1;
   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [TAP_WIDTH-1:0] LAST_TAP   = '1;
   localparam logic [CNT_W-1:0]     SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]     SAMPLE_END = CNT_W'(SAMPLE_CYCLES - 1);
   localparam logic [LEN_W-1:0]     MIN_LEN    = LEN_W'(MIN_WINDOW);

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, EVAL, FINAL, DONE} state_t;

   state_t               state_q, state_d;
   logic [TAP_WIDTH-1:0] tap_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 pass_q;
   logic                 run_open_q;
   logic [TAP_WIDTH-1:0] run_start_q, best_start_q;
   logic [LEN_W-1:0]     run_len_q, best_len_q;
   logic                 locked_q, error_q;
   logic [TAP_WIDTH-1:0] win_start_q, win_end_q;

   // per-bit compare of both DDR edges
   logic [WIDTH-1:0] lane_ok;
   logic             match;
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign lane_ok[i] = (bus.input_q1[i] == bus.pattern_q1[i]) &&
                          (bus.input_q2[i] == bus.pattern_q2[i]);
   end
   assign match = &lane_ok;

   // candidate run as it stands after this tap's result is folded in
   logic                 last_tap, cand_cmp, take_best, lock_ok;
   logic [TAP_WIDTH-1:0] cand_start, final_tap, final_end;
   logic [LEN_W-1:0]     cand_len;

   always_comb begin
      last_tap   = (tap_q == LAST_TAP);
      cand_start = run_open_q ? run_start_q : tap_q;
      cand_len   = run_open_q ? run_len_q + LEN_W'(1) : LEN_W'(1);
      cand_cmp   = last_tap;
      if (!pass_q) begin
         cand_start = run_start_q;
         cand_len   = run_len_q;
         cand_cmp   = run_open_q;
      end
      take_best  = cand_cmp && (cand_len > best_len_q);
      lock_ok    = (best_len_q >= MIN_LEN);
      final_tap  = lock_ok ? best_start_q + TAP_WIDTH'((best_len_q - LEN_W'(1)) >> 1) : '0;
      final_end  = lock_ok ? best_start_q + TAP_WIDTH'(best_len_q - LEN_W'(1)) : '0;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = LOAD;
         LOAD:    state_d = SETTLE;
         SETTLE:  if (cnt_q == SETTLE_END) state_d = SAMPLE;
         SAMPLE:  if (cnt_q == SAMPLE_END) state_d = EVAL;
         EVAL:    state_d = last_tap ? FINAL : LOAD;
         FINAL:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap_q <= '0; cnt_q <= '0; pass_q <= 1'b0;
         run_open_q <= 1'b0; run_start_q <= '0; run_len_q <= '0;
         best_start_q <= '0; best_len_q <= '0;
         locked_q <= 1'b0; error_q <= 1'b0; win_start_q <= '0; win_end_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (bus.start) begin
               tap_q <= '0;
               run_open_q <= 1'b0; run_start_q <= '0; run_len_q <= '0;
               best_start_q <= '0; best_len_q <= '0;
               locked_q <= 1'b0; error_q <= 1'b0; win_start_q <= '0; win_end_q <= '0;
            end
            LOAD: begin
               cnt_q  <= '0;
               pass_q <= 1'b1;
            end
            SETTLE: cnt_q <= (cnt_q == SETTLE_END) ? '0 : cnt_q + CNT_W'(1);
            SAMPLE: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (!match) pass_q <= 1'b0;
            end
            EVAL: begin
               if (pass_q) begin
                  run_open_q  <= 1'b1;
                  run_start_q <= cand_start;
                  run_len_q   <= cand_len;
               end else begin
                  run_open_q  <= 1'b0;
               end
               if (take_best) begin
                  best_start_q <= cand_start;
                  best_len_q   <= cand_len;
               end
               if (!last_tap) tap_q <= tap_q + TAP_WIDTH'(1);
            end
            FINAL: begin
               // tap register doubles as the held output once the scan ends
               tap_q       <= final_tap;
               locked_q    <= lock_ok;
               error_q     <= !lock_ok;
               win_start_q <= lock_ok ? best_start_q : '0;
               win_end_q   <= final_end;
            end
            default: ;
         endcase
      end
   end

   assign bus.delay_tap    = (state_q == FINAL) ? final_tap : tap_q;
   assign bus.delay_load   = (state_q == LOAD) || (state_q == FINAL);
   assign bus.busy         = (state_q != IDLE) && (state_q != DONE);
   assign bus.done         = (state_q == DONE);
   assign bus.locked       = locked_q;
   assign bus.error        = error_q;
   assign bus.window_start = win_start_q;
   assign bus.window_end   = win_end_q;
endmodule

// File: tb/tb_ssio_ddr_in_delay_ctrl.sv
// Scoreboard bench: each scan pushes its expected result, popped at the done pulse.
module tb_ssio_ddr_in_delay_ctrl;
   localparam int WIDTH = 4, TW = 3, SETTLE = 2, SAMPLE = 4, MINW = 2;
   localparam int NTAP = 8, TAP_CYC = 2 + SETTLE + SAMPLE, SCAN_CYC = NTAP * TAP_CYC + 2;

   typedef struct {
      logic          locked;
      logic          error;
      logic [TW-1:0] ws;
      logic [TW-1:0] we;
      logic [TW-1:0] ftap;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ssio_ddr_in_delay_ctrl_if #(.WIDTH(WIDTH), .TAP_WIDTH(TW)) bus ();

   ssio_ddr_in_delay_ctrl #(
      .WIDTH(WIDTH), .TAP_WIDTH(TW), .SETTLE_CYCLES(SETTLE),
      .SAMPLE_CYCLES(SAMPLE), .MIN_WINDOW(MINW)
   ) u_dut (.clk(clk), .rst(rst), .bus(bus));

   int            checks = 0, errors = 0;
   exp_t          sb_q[$];
   logic [NTAP-1:0] pass_mask = '0;
   logic          glitch_en = 1'b0;
   int            glitch_tap = 0;
   logic [TW-1:0] cur_tap = '0;
   logic [TW-1:0] last_load_tap = '0;
   int            since_load = 0;

   // delay-line model: latches the tap on each load, counts cycles since
   always @(negedge clk) begin
      if (bus.delay_load) begin
         cur_tap       <= bus.delay_tap;
         last_load_tap <= bus.delay_tap;
         since_load    <= 0;
      end else begin
         since_load    <= since_load + 1;
      end
   end

   // since_load==5 is the third SAMPLE cycle after a load
   logic good;
   always_comb begin
      good = pass_mask[cur_tap] && !(glitch_en && (int'(cur_tap) == glitch_tap) && since_load == 5);
      bus.input_q1 = bus.pattern_q1 ^ ((!good && !cur_tap[0]) ? 4'b0100 : 4'b0000);
      bus.input_q2 = bus.pattern_q2 ^ ((!good &&  cur_tap[0]) ? 4'b0001 : 4'b0000);
   end

   function automatic exp_t model(input logic [NTAP-1:0] m);
      exp_t e;
      int bs = 0, bl = 0, rs = 0, rl = 0;
      for (int t = 0; t < NTAP; t++) begin
         if (m[t]) begin
            if (rl == 0) rs = t;
            rl++;
         end else rl = 0;
         if (rl > bl) begin bl = rl; bs = rs; end
      end
      if (bl >= MINW) begin
         e.locked = 1'b1; e.error = 1'b0;
         e.ws = TW'(bs); e.we = TW'(bs + bl - 1); e.ftap = TW'(bs + (bl - 1) / 2);
      end else begin
         e.locked = 1'b0; e.error = 1'b1; e.ws = '0; e.we = '0; e.ftap = '0;
      end
      return e;
   endfunction

   task automatic test_scan(input string name, input logic [NTAP-1:0] m,
                            input bit gl, input int gt, input bit extra_start);
      exp_t g;
      logic [NTAP-1:0] eff;
      int dones = 0, done_cyc = -1;
      eff = m;
      if (gl) eff[gt] = 1'b0;
      pass_mask = m; glitch_en = gl; glitch_tap = gt;
      bus.pattern_q1 = 4'($urandom); bus.pattern_q2 = 4'($urandom);
      sb_q.push_back(model(eff));
      @(negedge clk); bus.start = 1'b1;
      for (int cyc = 1; cyc <= SCAN_CYC + 10; cyc++) begin
         @(negedge clk);
         bus.start = (extra_start && (cyc == 20 || cyc == 45)) ? 1'b1 : 1'b0;
         if (cyc == 1) begin
            checks++;
            if ({bus.busy, bus.delay_load, bus.delay_tap} !== {1'b1, 1'b1, TW'(0)}) begin
               errors++;
               $display("FAIL %s first_load: got busy/load/tap %b/%b/%0d want 1/1/0", name, bus.busy, bus.delay_load, bus.delay_tap);
            end
         end
         if (bus.done === 1'b1) begin
            dones++;
            if (dones == 1 && sb_q.size() > 0) begin
               done_cyc = cyc;
               g = sb_q.pop_front();
               checks++;
               if ({bus.locked, bus.error} !== {g.locked, g.error}) begin
                  errors++;
                  $display("FAIL %s locked/error: got %b%b want %b%b", name, bus.locked, bus.error, g.locked, g.error);
               end
               checks++;
               if ({bus.window_start, bus.window_end} !== {g.ws, g.we}) begin
                  errors++;
                  $display("FAIL %s window: got %0d..%0d want %0d..%0d", name, bus.window_start, bus.window_end, g.ws, g.we);
               end
               checks++;
               if (last_load_tap !== g.ftap) begin
                  errors++;
                  $display("FAIL %s final_load_tap: got %0d want %0d", name, last_load_tap, g.ftap);
               end
               checks++;
               if (bus.busy !== 1'b0) begin
                  errors++;
                  $display("FAIL %s busy_at_done: got %b want 0", name, bus.busy);
               end
            end
         end
      end
      checks++;
      if (dones != 1 || done_cyc != SCAN_CYC) begin
         errors++;
         $display("FAIL %s done_timing: got %0d pulses at cycle %0d want 1 at %0d", name, dones, done_cyc, SCAN_CYC);
      end
      checks++;
      if (dones >= 1 && {bus.delay_tap, bus.locked, bus.window_end, bus.busy} !== {g.ftap, g.locked, g.we, 1'b0}) begin
         errors++;
         $display("FAIL %s hold: got tap %0d locked %b end %0d busy %b want %0d %b %0d 0",
                  name, bus.delay_tap, bus.locked, bus.window_end, bus.busy, g.ftap, g.locked, g.we);
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s scoreboard: %0d results never produced, want 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0;
      bus.pattern_q1 = 4'hA; bus.pattern_q2 = 4'h5;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.delay_tap, bus.delay_load, bus.busy, bus.done, bus.locked, bus.error,
           bus.window_start, bus.window_end} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got tap %0d load %b busy %b done %b",
                  bus.delay_tap, bus.delay_load, bus.busy, bus.done);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_scan();
      int waited = 0, dones = 0;
      pass_mask = 8'b0011_1100; glitch_en = 1'b0;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      while (!(cur_tap == 3'd4 && since_load == 4) && waited < 200) begin
         @(negedge clk); waited++;
      end
      checks++;
      if (waited >= 200) begin
         errors++;
         $display("FAIL midreset_reach_tap4: waited %0d cycles, want < 200", waited);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.delay_tap, bus.delay_load, bus.busy, bus.done, bus.locked, bus.error,
           bus.window_start, bus.window_end} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got tap %0d load %b busy %b done %b, want all 0",
                  bus.delay_tap, bus.delay_load, bus.busy, bus.done);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL midreset_no_resume: got %0d busy/done cycles want 0", dones);
      end
      test_scan("after_reset", 8'b0011_1100, 1'b0, 0, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_scan("pass_2_5",     8'b0011_1100, 1'b0, 0, 1'b0);
      test_scan("two_runs",     8'b0111_0110, 1'b0, 0, 1'b0);
      test_scan("tie_earlier",  8'b0011_0011, 1'b0, 0, 1'b0);
      test_scan("open_at_last", 8'b1100_0000, 1'b0, 0, 1'b0);
      test_scan("glitch_tap4",  8'b0011_1100, 1'b1, 4, 1'b0);
      test_scan("single_tap",   8'b0000_1000, 1'b0, 0, 1'b0);
      test_scan("no_pass",      8'b0000_0000, 1'b0, 0, 1'b0);
      test_scan("full_range",   8'b1111_1111, 1'b0, 0, 1'b0);
      test_scan("start_ignored", 8'b0001_1110, 1'b0, 0, 1'b1);
      test_reset_mid_scan();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ssio_ddr_in_delay_ctrl.md
SSIO_DDR_IN_DELAY_CTRL -- requirements
Module: ssio_ddr_in_delay_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: data bit width of the monitored DDR input path.
REQ-002 Parameter TAP_WIDTH, default 5: delay tap index width; taps 0..2^TAP_WIDTH-1.
REQ-003 Parameter SETTLE_CYCLES, default 16: wait cycles after each tap load before sampling; must be >=1.
REQ-004 Parameter SAMPLE_CYCLES, default 64: compare cycles per tap; must be >=1.
REQ-005 Parameter MIN_WINDOW, default 3: minimum passing window length, in taps, needed to lock.
REQ-006 clk  input  1: sole clock; the output_clk domain of the DDR input path. One clock; all logic is on rising edge.
REQ-007 rst  input  1: asynchronous, active-high reset.
REQ-008 start  input  1: request a calibration scan; sampled only in IDLE.
REQ-009 pattern_q1 / pattern_q2  input  WIDTH each: expected training values for rising- and falling-edge data.
REQ-010 input_q1 / input_q2  input  WIDTH each: captured DDR data from the input path.
REQ-011 delay_tap  output  TAP_WIDTH: tap value presented to the input delay elements.
REQ-012 delay_load  output  1: one-cycle strobe; delay elements load delay_tap when it is high.
REQ-013 busy  output  1: high from the cycle after an accepted start until done.
REQ-014 done  output  1: one-cycle pulse at the end of the scan.
REQ-015 locked  output  1: high when the last scan found a valid window.
REQ-016 error  output  1: high when the last scan failed.
REQ-017 window_start / window_end  output  TAP_WIDTH each: first and last tap of the chosen window.

Function
REQ-018 States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, FINAL, DONE.
REQ-019 IDLE with start=1: next cycle enters LOAD with tap counter 0; clear locked, error and window registers; set busy=1.
- start is ignored in all states other than IDLE.
REQ-020 LOAD lasts 1 cycle: delay_load=1 and delay_tap=current tap.
REQ-021 SETTLE lasts exactly SETTLE_CYCLES cycles; input data is ignored.
REQ-022 SAMPLE lasts exactly SAMPLE_CYCLES cycles.
- A tap passes only if {input_q1,input_q2}=={pattern_q1,pattern_q2} on every SAMPLE cycle.
REQ-023 EVAL lasts 1 cycle and updates window tracking.
- Pass with no open run: open a run at the current tap, length 1.
- Pass with an open run: increment the run length.
- Fail: close the run.
- When a run closes, or the tap is the last tap, compare the run length with the best length.
- Replace best only if strictly longer; ties keep the earlier window.
REQ-024 After EVAL:
- If tap < 2^TAP_WIDTH-1: increment tap and go to LOAD.
- Otherwise go to FINAL. The tap counter does not wrap.
- Each tap takes exactly 2+SETTLE_CYCLES+SAMPLE_CYCLES cycles.
REQ-025 Run and best lengths are TAP_WIDTH+1 bits wide, so a full-range window (2^TAP_WIDTH) is representable.
REQ-026 FINAL, best length >= MIN_WINDOW:
- delay_tap = best_start + floor((best_len-1)/2); delay_load=1 for 1 cycle.
- window_start = best_start; window_end = best_start+best_len-1; locked set.
REQ-027 FINAL, best length < MIN_WINDOW (including no passing tap):
- delay_tap=0 with delay_load=1 for 1 cycle; error set.
- locked=0; window_start and window_end are 0.
REQ-028 DONE lasts 1 cycle: done=1, busy=0 in the same cycle, then return to IDLE.
- locked, error, window registers and delay_tap hold until the next accepted start or rst.
REQ-029 delay_load is high only in LOAD and FINAL.

Reset
REQ-030 While rst=1, regardless of state:
- All outputs are 0: delay_tap, delay_load, busy, done, locked, error, window_start, window_end.
- FSM goes to IDLE; all counters and window trackers are cleared.
REQ-031 Reset asserted mid-scan aborts the scan without a done pulse. A new start is required after rst deasserts.

Verification
All scenarios use TAP_WIDTH=3, SETTLE_CYCLES=2, SAMPLE_CYCLES=4, MIN_WINDOW=2. The bench drives data matching the pattern only at the listed taps.
REQ-032 Pass taps 2..5 -> locked=1, window_start=2, window_end=5, final delay_tap=3. done occurs 8*8+2 cycles after start.
REQ-033 Pass taps {1,2} and {4,5,6} -> window 4..6, final tap 5. Pass {0,1} and {4,5} (tie) -> window 0..1, final tap 0.
REQ-034 Pass taps {6,7} (run open at last tap) -> window 6..7, final tap 6, locked=1.
REQ-035 Pass taps 2..5, with one mismatching sample on the third SAMPLE cycle of tap 4 -> tap 4 fails; window 2..3, final tap 2.
REQ-036 Pass only tap 3 -> error=1, locked=0, final delay_load with tap 0, window outputs 0.
REQ-037 Control and reset behaviour:
- start pulsed during the scan -> no restart; exactly one done pulse.
- rst asserted during SAMPLE of tap 4 -> all outputs 0 immediately, no done; a new start runs a full scan from tap 0.
